tqvp_uart_bus_bridge: RTL and testbench

UART-driven bus initiator for TinyQV peripherals: it receives command frames on a UART RX line and issues 8/16/32-bit reads and writes on the peripheral bus (address, data, data_write_n, data_read_n, data_ready). Responses go back on a UART TX line. It sits at the opposite end of the peripheral interface from the UART peripheral, so a host PC can poke peripheral registers without the CPU. Fixed baud divider, 8N1 framing, one transaction in flight.

---
 rtl/tqvp_uart_bus_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_tqvp_uart_bus_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_uart_bus_bridge.sv
// UART-driven TinyQV peripheral bus initiator: parses CMD/ADDR/DATA frames from uart_rxd,
// performs one 8/16/32-bit bus read or write, and answers with ACK, NAK or read data on uart_txd.
module tqvp_uart_bus_bridge #(
   parameter int unsigned BAUD_DIVIDER = 555
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rxd,
   output logic        uart_txd,
   output logic [5:0]  address,
   output logic [31:0] data_out,
   output logic [1:0]  data_write_n,
   output logic [1:0]  data_read_n,
   input  logic [31:0] data_in,
   input  logic        data_ready,
   output logic        busy
);
   localparam int unsigned   CW        = $clog2(BAUD_DIVIDER);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIVIDER - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIVIDER / 2 - 1);
   localparam logic [7:0]    ACK       = 8'h06;
   localparam logic [7:0]    NAK       = 8'h15;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS_WR, S_BUS_RD, S_RESP} state_t;

   logic          rx_s1, rx_s2, rx_prev;
   rx_state_t     rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_byte;
   logic          rx_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_s1    <= uart_rxd;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt  <= '0;
                  rx_byte <= {rx_s2, rx_byte[7:1]};
                  rx_bit  <= rx_bit + 1'b1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_valid <= rx_s2;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   state_t        state;
   logic          is_write;
   logic [1:0]    size;
   logic [1:0]    byte_idx;
   logic [1:0]    last_idx;
   logic [1:0]    resp_left;
   logic [31:0]   resp_data;
   logic          illegal_cmd;
   logic          tx_load, tx_active, tx_done;
   logic [7:0]    tx_load_byte;
   logic [8:0]    tx_shift;
   logic [3:0]    tx_bit;
   logic [CW-1:0] tx_cnt;

   assign illegal_cmd = rx_byte[7] || (rx_byte[5:4] == 2'b11);
   assign last_idx    = (size == 2'b10) ? 2'd3 : size;
   assign tx_done     = tx_active && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);

   // Next response byte is loaded on the stop bit's final cycle so bytes abut without idle gap.
   always_comb begin
      tx_load      = 1'b0;
      tx_load_byte = '0;
      case (state)
         S_IDLE:   if (rx_valid && illegal_cmd) begin tx_load = 1'b1; tx_load_byte = NAK; end
         S_BUS_WR: begin tx_load = 1'b1; tx_load_byte = ACK; end
         S_BUS_RD: if (data_ready) begin tx_load = 1'b1; tx_load_byte = data_in[7:0]; end
         S_RESP:   if (tx_done && resp_left != 2'd0) begin tx_load = 1'b1; tx_load_byte = resp_data[7:0]; end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uart_txd  <= 1'b1;
         tx_active <= 1'b0;
         tx_shift  <= '1;
         tx_bit    <= '0;
         tx_cnt    <= '0;
      end else if (tx_load) begin
         uart_txd  <= 1'b0;
         tx_shift  <= {1'b1, tx_load_byte};
         tx_bit    <= '0;
         tx_cnt    <= '0;
         tx_active <= 1'b1;
      end else if (tx_active) begin
         if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
               tx_active <= 1'b0;
            end else begin
               uart_txd <= tx_shift[0];
               tx_shift <= {1'b1, tx_shift[8:1]};
               tx_bit   <= tx_bit + 1'b1;
            end
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         address      <= '0;
         data_out     <= '0;
         data_write_n <= '1;
         data_read_n  <= '1;
         is_write     <= 1'b0;
         size         <= '0;
         byte_idx     <= '0;
         resp_left    <= '0;
         resp_data    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  busy <= 1'b1;
                  if (illegal_cmd) begin
                     resp_left <= '0;
                     state     <= S_RESP;
                  end else begin
                     is_write <= rx_byte[6];
                     size     <= rx_byte[5:4];
                     state    <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (rx_valid) begin
                  address  <= rx_byte[5:0];
                  byte_idx <= '0;
                  if (is_write) begin
                     data_out <= '0;
                     state    <= S_WDATA;
                  end else begin
                     data_read_n <= size;
                     state       <= S_BUS_RD;
                  end
               end
            end
            S_WDATA: begin
               if (rx_valid) begin
                  data_out[{byte_idx, 3'b000} +: 8] <= rx_byte;
                  byte_idx <= byte_idx + 1'b1;
                  if (byte_idx == last_idx) begin
                     data_write_n <= size;
                     state        <= S_BUS_WR;
                  end
               end
            end
            S_BUS_WR: begin
               data_write_n <= '1;
               resp_left    <= '0;
               state        <= S_RESP;
            end
            S_BUS_RD: begin
               if (data_ready) begin
                  data_read_n <= '1;
                  resp_data   <= {8'h00, data_in[31:8]};
                  resp_left   <= last_idx;
                  state       <= S_RESP;
               end
            end
            S_RESP: begin
               if (tx_done) begin
                  if (resp_left == 2'd0) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     resp_data <= {8'h00, resp_data[31:8]};
                     resp_left <= resp_left - 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tqvp_uart_bus_bridge.sv
// Bench for tqvp_uart_bus_bridge: drives UART command frames, models a peripheral, and
// decodes the TX line independently to compare bus activity and responses with expected values.
module tb_tqvp_uart_bus_bridge;
   localparam int BAUD = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        uart_rxd = 1'b1;
   logic        uart_txd;
   logic [5:0]  address;
   logic [31:0] data_out;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_in;
   logic        data_ready;
   logic        busy;

   tqvp_uart_bus_bridge #(.BAUD_DIVIDER(BAUD)) dut (
      .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
      .address(address), .data_out(data_out), .data_write_n(data_write_n),
      .data_read_n(data_read_n), .data_in(data_in), .data_ready(data_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
      logic [1:0]  width;
      int          run;
      int          last_cyc;
   } bus_ev_t;

   bus_ev_t     wr_q[$];
   bus_ev_t     rd_q[$];
   logic [7:0]  tx_q[$];
   int          tx_start_q[$];
   int          tx_stop_bad = 0;
   int          cyc = 0;
   int          idle_cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic        hold_ready = 1'b0;
   int          rd_delay = 0;
   logic [31:0] rd_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Peripheral model: raises data_ready once a request has lasted rd_delay+1 cycles.
   initial begin
      int req;
      req = 0;
      data_ready = 1'b0;
      data_in = '0;
      forever begin
         @(negedge clk);
         if (data_read_n !== 2'b11) req++;
         else req = 0;
         data_ready = hold_ready || (req > rd_delay);
         data_in = data_ready ? rd_data : $urandom;
      end
   end

   initial begin
      bus_ev_t w, r;
      w.run = 0;
      r.run = 0;
      forever begin
         @(negedge clk);
         if (data_write_n !== 2'b11) begin
            if (w.run == 0) begin w.addr = address; w.data = data_out; w.width = data_write_n; end
            w.run++;
            w.last_cyc = cyc;
         end else if (w.run != 0) begin
            wr_q.push_back(w);
            w.run = 0;
         end
         if (data_read_n !== 2'b11) begin
            if (r.run == 0) begin r.addr = address; r.data = '0; r.width = data_read_n; end
            r.run++;
            r.last_cyc = cyc;
         end else if (r.run != 0) begin
            rd_q.push_back(r);
            r.run = 0;
         end
      end
   end

   initial begin
      logic [7:0] b;
      int s;
      forever begin
         @(negedge clk);
         if (uart_txd === 1'b0) begin
            s = cyc;
            repeat (BAUD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BAUD) @(negedge clk);
               b[i] = uart_txd;
            end
            repeat (BAUD) @(negedge clk);
            if (uart_txd !== 1'b1) tx_stop_bad++;
            tx_q.push_back(b);
            tx_start_q.push_back(s);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (BAUD) @(negedge clk);
      end
      uart_rxd = stop_bit;
      repeat (BAUD) @(negedge clk);
      uart_rxd = 1'b1;
   endtask

   task automatic wait_idle(input int nbytes);
      int t;
      t = 0;
      while ((tx_q.size() < nbytes || busy !== 1'b0) && t < 12 * BAUD * (nbytes + 1) + 200) begin
         @(negedge clk);
         t++;
      end
      idle_cyc = cyc;
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_logs();
      tx_q.delete();
      tx_start_q.delete();
      wr_q.delete();
      rd_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (uart_txd !== 1'b1) begin $display("FAIL reset_txd: got %b want 1", uart_txd); bad++; end
      total++; if (address !== 6'h00) begin $display("FAIL reset_address: got %h want 00", address); bad++; end
      total++; if (data_out !== 32'h0) begin $display("FAIL reset_data_out: got %h want 0", data_out); bad++; end
      total++; if (data_write_n !== 2'b11) begin $display("FAIL reset_write_n: got %b want 11", data_write_n); bad++; end
      total++; if (data_read_n !== 2'b11) begin $display("FAIL reset_read_n: got %b want 11", data_read_n); bad++; end
      total++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); bad++; end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_write32();
      logic [7:0] frame [6];
      frame = '{8'h60, 8'h08, 8'h78, 8'h56, 8'h34, 8'h12};
      clear_logs();
      for (int i = 0; i < 6; i++) send_byte(frame[i], 1'b1);
      wait_idle(1);
      total++; if (wr_q.size() != 1) begin $display("FAIL wr32_count: got %0d want 1", wr_q.size()); bad++; end
      if (wr_q.size() == 1) begin
         total++; if (wr_q[0].addr !== 6'h08) begin $display("FAIL wr32_addr: got %h want 08", wr_q[0].addr); bad++; end
         total++; if (wr_q[0].data !== 32'h12345678) begin $display("FAIL wr32_data: got %h want 12345678", wr_q[0].data); bad++; end
         total++; if (wr_q[0].width !== 2'b10) begin $display("FAIL wr32_width: got %b want 10", wr_q[0].width); bad++; end
         total++; if (wr_q[0].run != 1) begin $display("FAIL wr32_strobe_len: got %0d want 1", wr_q[0].run); bad++; end
      end
      total++; if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin $display("FAIL wr32_ack: got %0d bytes first %h want 1 byte 06", tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 8'h00); bad++; end
      if (tx_q.size() == 1 && wr_q.size() == 1) begin
         total++; if (tx_start_q[0] - wr_q[0].last_cyc != 1) begin $display("FAIL wr32_tx_latency: got %0d want 1", tx_start_q[0] - wr_q[0].last_cyc); bad++; end
         total++; if (idle_cyc - tx_start_q[0] != 10 * BAUD) begin $display("FAIL wr32_busy_fall: got %0d want %0d", idle_cyc - tx_start_q[0], 10 * BAUD); bad++; end
      end
      total++; if (address !== 6'h08 || data_out !== 32'h12345678) begin $display("FAIL wr32_hold: got %h/%h want 08/12345678", address, data_out); bad++; end
      total++; if (rd_q.size() != 0) begin $display("FAIL wr32_no_read: got %0d want 0", rd_q.size()); bad++; end
   endtask

   task automatic test_read8();
      clear_logs();
      hold_ready = 1'b1;
      rd_data = 32'h000000A5;
      send_byte(8'h00, 1'b1);
      send_byte(8'h04, 1'b1);
      wait_idle(1);
      hold_ready = 1'b0;
      total++; if (rd_q.size() != 1) begin $display("FAIL rd8_count: got %0d want 1", rd_q.size()); bad++; end
      if (rd_q.size() == 1) begin
         total++; if (rd_q[0].addr !== 6'h04 || rd_q[0].width !== 2'b00) begin $display("FAIL rd8_req: got %h/%b want 04/00", rd_q[0].addr, rd_q[0].width); bad++; end
         total++; if (rd_q[0].run != 1) begin $display("FAIL rd8_req_len: got %0d want 1", rd_q[0].run); bad++; end
      end
      total++; if (tx_q.size() != 1 || tx_q[0] !== 8'hA5) begin $display("FAIL rd8_resp: got %0d bytes first %h want A5", tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 8'h00); bad++; end
      if (tx_q.size() == 1 && rd_q.size() == 1) begin
         total++; if (tx_start_q[0] - rd_q[0].last_cyc != 1) begin $display("FAIL rd8_tx_latency: got %0d want 1", tx_start_q[0] - rd_q[0].last_cyc); bad++; end
      end
   endtask

   task automatic test_read16_delay();
      clear_logs();
      rd_delay = 5;
      rd_data = 32'h0000BEEF;
      send_byte(8'h10, 1'b1);
      send_byte(8'h21, 1'b1);
      wait_idle(2);
      total++; if (rd_q.size() != 1) begin $display("FAIL rd16_count: got %0d want 1", rd_q.size()); bad++; end
      if (rd_q.size() == 1) begin
         total++; if (rd_q[0].run != 6) begin $display("FAIL rd16_req_len: got %0d want 6", rd_q[0].run); bad++; end
         total++; if (rd_q[0].width !== 2'b01 || rd_q[0].addr !== 6'h21) begin $display("FAIL rd16_req: got %b/%h want 01/21", rd_q[0].width, rd_q[0].addr); bad++; end
      end
      total++; if (tx_q.size() != 2) begin $display("FAIL rd16_nbytes: got %0d want 2", tx_q.size()); bad++; end
      if (tx_q.size() == 2) begin
         total++; if (tx_q[0] !== 8'hEF || tx_q[1] !== 8'hBE) begin $display("FAIL rd16_bytes: got %h %h want EF BE", tx_q[0], tx_q[1]); bad++; end
         total++; if (tx_start_q[1] - tx_start_q[0] != 10 * BAUD) begin $display("FAIL rd16_no_gap: got %0d want %0d", tx_start_q[1] - tx_start_q[0], 10 * BAUD); bad++; end
      end
      rd_delay = 0;
   endtask

   task automatic test_illegal();
      clear_logs();
      send_byte(8'h30, 1'b1);
      wait_idle(1);
      total++; if (tx_q.size() != 1 || tx_q[0] !== 8'h15) begin $display("FAIL nak_resp: got %0d bytes first %h want 15", tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 8'h00); bad++; end
      total++; if (wr_q.size() + rd_q.size() != 0) begin $display("FAIL nak_no_bus: got %0d events want 0", wr_q.size() + rd_q.size()); bad++; end
      clear_logs();
      send_byte(8'h40, 1'b1);
      send_byte(8'h0C, 1'b1);
      send_byte(8'h01, 1'b1);
      wait_idle(1);
      total++; if (wr_q.size() != 1) begin $display("FAIL after_nak_count: got %0d want 1", wr_q.size()); bad++; end
      if (wr_q.size() == 1) begin
         total++; if (wr_q[0].addr !== 6'h0C || wr_q[0].data !== 32'h1 || wr_q[0].width !== 2'b00) begin $display("FAIL after_nak_write: got %h/%h/%b want 0C/00000001/00", wr_q[0].addr, wr_q[0].data, wr_q[0].width); bad++; end
      end
      total++; if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin $display("FAIL after_nak_ack: got %0d bytes want 1 byte 06", tx_q.size()); bad++; end
   endtask

   task automatic test_framing();
      clear_logs();
      send_byte(8'h60, 1'b0);
      repeat (3 * BAUD) @(negedge clk);
      total++; if (busy !== 1'b0) begin $display("FAIL frame_err_busy: got %b want 0", busy); bad++; end
      rd_data = 32'h5A5A5A3C;
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      wait_idle(1);
      total++; if (rd_q.size() != 1 || wr_q.size() != 0) begin $display("FAIL frame_err_bus: got rd=%0d wr=%0d want rd=1 wr=0", rd_q.size(), wr_q.size()); bad++; end
      total++; if (tx_q.size() != 1 || tx_q[0] !== 8'h3C) begin $display("FAIL frame_err_resp: got %0d bytes first %h want 3C", tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 8'h00); bad++; end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      send_byte(8'h60, 1'b1);
      send_byte(8'h08, 1'b1);
      send_byte(8'h11, 1'b1);
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (BAUD + 3 * BAUD) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (uart_txd !== 1'b1 || busy !== 1'b0) begin $display("FAIL midrst_txd_busy: got %b/%b want 1/0", uart_txd, busy); bad++; end
      total++; if (address !== 6'h00 || data_out !== 32'h0) begin $display("FAIL midrst_regs: got %h/%h want 00/0", address, data_out); bad++; end
      total++; if (data_write_n !== 2'b11 || data_read_n !== 2'b11) begin $display("FAIL midrst_strobes: got %b/%b want 11/11", data_write_n, data_read_n); bad++; end
      uart_rxd = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (12 * BAUD) @(negedge clk);
      total++; if (wr_q.size() != 0 || tx_q.size() != 0) begin $display("FAIL midrst_quiet: got wr=%0d tx=%0d want 0/0", wr_q.size(), tx_q.size()); bad++; end
      clear_logs();
      send_byte(8'h50, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b1);
      wait_idle(1);
      total++; if (wr_q.size() != 1) begin $display("FAIL postrst_count: got %0d want 1", wr_q.size()); bad++; end
      if (wr_q.size() == 1) begin
         total++; if (wr_q[0].addr !== 6'h3F || wr_q[0].data !== 32'h0000CDAB || wr_q[0].width !== 2'b01) begin $display("FAIL postrst_write: got %h/%h/%b want 3F/0000CDAB/01", wr_q[0].addr, wr_q[0].data, wr_q[0].width); bad++; end
      end
      total++; if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin $display("FAIL postrst_ack: got %0d bytes want 1 byte 06", tx_q.size()); bad++; end
   endtask

   task automatic test_random();
      for (int n = 0; n < 16; n++) begin
         logic [7:0]  cmd, adr;
         logic [31:0] d, mask;
         int kind, sz, nb;
         kind = $urandom_range(0, 9);
         sz = $urandom_range(0, 2);
         nb = (sz == 2) ? 4 : sz + 1;
         adr = 8'($urandom);
         d = $urandom;
         clear_logs();
         if (kind < 2) begin
            cmd = 8'($urandom);
            if (!cmd[7]) cmd[5:4] = 2'b11;
            send_byte(cmd, 1'b1);
            wait_idle(1);
            total++; if (tx_q.size() != 1 || tx_q[0] !== 8'h15) begin $display("FAIL rand_nak[%0d]: cmd %h got %0d bytes want 15", n, cmd, tx_q.size()); bad++; end
            total++; if (wr_q.size() + rd_q.size() != 0) begin $display("FAIL rand_nak_bus[%0d]: got %0d events want 0", n, wr_q.size() + rd_q.size()); bad++; end
         end else if (kind < 6) begin
            cmd = {2'b01, 2'(sz), 4'($urandom)};
            send_byte(cmd, 1'b1);
            send_byte(adr, 1'b1);
            for (int i = 0; i < nb; i++) begin
               send_byte(d[8*i +: 8], 1'b1);
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle(1);
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
            total++; if (wr_q.size() != 1) begin $display("FAIL rand_wr_count[%0d]: got %0d want 1", n, wr_q.size()); bad++; end
            if (wr_q.size() == 1) begin
               total++; if (wr_q[0].addr !== adr[5:0] || wr_q[0].width !== 2'(sz)) begin $display("FAIL rand_wr_req[%0d]: got %h/%b want %h/%0d", n, wr_q[0].addr, wr_q[0].width, adr[5:0], sz); bad++; end
               total++; if (wr_q[0].data !== (d & mask)) begin $display("FAIL rand_wr_data[%0d]: got %h want %h", n, wr_q[0].data, d & mask); bad++; end
               total++; if (wr_q[0].run != 1) begin $display("FAIL rand_wr_len[%0d]: got %0d want 1", n, wr_q[0].run); bad++; end
            end
            total++; if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin $display("FAIL rand_wr_ack[%0d]: got %0d bytes want 06", n, tx_q.size()); bad++; end
         end else begin
            rd_delay = $urandom_range(0, 6);
            rd_data = d;
            cmd = {2'b00, 2'(sz), 4'($urandom)};
            send_byte(cmd, 1'b1);
            send_byte(adr, 1'b1);
            wait_idle(nb);
            total++; if (rd_q.size() != 1) begin $display("FAIL rand_rd_count[%0d]: got %0d want 1", n, rd_q.size()); bad++; end
            if (rd_q.size() == 1) begin
               total++; if (rd_q[0].addr !== adr[5:0] || rd_q[0].width !== 2'(sz)) begin $display("FAIL rand_rd_req[%0d]: got %h/%b want %h/%0d", n, rd_q[0].addr, rd_q[0].width, adr[5:0], sz); bad++; end
               total++; if (rd_q[0].run != rd_delay + 1) begin $display("FAIL rand_rd_len[%0d]: got %0d want %0d", n, rd_q[0].run, rd_delay + 1); bad++; end
            end
            total++; if (tx_q.size() != nb) begin $display("FAIL rand_rd_nbytes[%0d]: got %0d want %0d", n, tx_q.size(), nb); bad++; end
            for (int i = 0; i < nb && i < tx_q.size(); i++) begin
               total++; if (tx_q[i] !== d[8*i +: 8]) begin $display("FAIL rand_rd_byte[%0d.%0d]: got %h want %h", n, i, tx_q[i], d[8*i +: 8]); bad++; end
            end
            rd_delay = 0;
         end
         repeat ($urandom_range(0, BAUD)) @(negedge clk);
      end
      total++; if (tx_stop_bad != 0) begin $display("FAIL tx_stop_bits: got %0d bad stop bits want 0", tx_stop_bad); bad++; end
   endtask

   initial begin
      test_reset();
      test_write32();
      test_read8();
      test_read16_delay();
      test_illegal();
      test_framing();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
